// File: rtl/dbus_write_buffer_pkg.sv
// Bus request/response types and write-buffer state types for the data-bus
// write buffer.
package dbus_write_buffer_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {D_IDLE, D_ADDR, D_DATA} drain_stat_t;
  typedef enum logic [1:0] {L_IDLE, L_ADDR, L_DATA} load_stat_t;

  function automatic logic is_store(dbus_req_t r);
    return r.valid && (r.strobe != 4'b0000);
  endfunction

endpackage

// File: rtl/dbus_write_buffer_fifo.sv
// Circular store FIFO; pointers wrap modulo DEPTH (power of two).
module wb_fifo
  import dbus_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_data,
  input  logic                     pop,
  output wb_entry_t                head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[head_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + AW'(1);
    end
    if (pop_ok) head_d = head_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dbus_write_buffer.sv
// Write buffer between core dbus and memory: stores are acked at once and
// drained in order; loads pass through only when the buffer is empty.
//
// state  | meaning
// D_IDLE | no write outstanding; issues head entry combinationally when count>0
// D_ADDR | head write presented, waiting for mresp.addr_ok
// D_DATA | head write accepted, waiting for mresp.data_ok
// L_IDLE | no load outstanding
// L_ADDR | load forwarded to memory, waiting for mresp.addr_ok
// L_DATA | load accepted, response passed through on mresp.data_ok
module dbus_write_buffer
  import dbus_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  creq,
  output dbus_resp_t cresp,
  output dbus_req_t  mreq,
  input  dbus_resp_t mresp
);

  drain_stat_t d_q, d_d;
  load_stat_t  l_q, l_d;

  wb_entry_t                 head_data, push_data;
  logic                      full, empty, push, pop;
  logic [$clog2(DEPTH):0]    count;
  logic                      drain_issue, store_acc, load_start;

  assign push_data   = '{addr: creq.addr, size: creq.size, strobe: creq.strobe, data: creq.data};
  assign store_acc   = is_store(creq) && !full && !reset;
  assign push        = store_acc;
  // Idle drain presents the head immediately so a store reaches memory one cycle after its ack.
  assign drain_issue = ((d_q == D_IDLE) && !empty && (l_q == L_IDLE)) || (d_q == D_ADDR);
  assign load_start  = creq.valid && (creq.strobe == 4'b0000) && empty && (d_q == D_IDLE);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= D_IDLE;
      l_q <= L_IDLE;
    end else begin
      d_q <= d_d;
      l_q <= l_d;
    end
  end

  always_comb begin
    d_d = d_q;
    l_d = l_q;
    case (d_q)
      D_IDLE: if (drain_issue) d_d = mresp.addr_ok ? (mresp.data_ok ? D_IDLE : D_DATA) : D_ADDR;
      D_ADDR: if (mresp.addr_ok) d_d = mresp.data_ok ? D_IDLE : D_DATA;
      D_DATA: if (mresp.data_ok) d_d = D_IDLE;
      default: d_d = D_IDLE;
    endcase
    case (l_q)
      L_IDLE: if (load_start) l_d = L_ADDR;
      L_ADDR: if (mresp.addr_ok) l_d = mresp.data_ok ? L_IDLE : L_DATA;
      L_DATA: if (mresp.data_ok) l_d = L_IDLE;
      default: l_d = L_IDLE;
    endcase
  end

  always_comb begin
    mreq  = '0;
    cresp = '0;
    pop   = 1'b0;
    if (store_acc) begin
      cresp.addr_ok = 1'b1;
      cresp.data_ok = 1'b1;
    end
    if (drain_issue) begin
      mreq.valid  = 1'b1;
      mreq.addr   = head_data.addr;
      mreq.size   = head_data.size;
      mreq.strobe = head_data.strobe;
      mreq.data   = head_data.data;
      pop         = mresp.addr_ok && mresp.data_ok;
    end
    if (d_q == D_DATA) pop = mresp.data_ok;
    if (l_q == L_ADDR) begin
      mreq          = creq;
      cresp.addr_ok = mresp.addr_ok;
      cresp.data_ok = mresp.addr_ok && mresp.data_ok;
      cresp.data    = mresp.data;
    end
    if (l_q == L_DATA) begin
      cresp.data_ok = cresp.data_ok | mresp.data_ok;
      cresp.data    = mresp.data;
    end
  end

endmodule
